// File: rtl/shield_spi_pkg.sv
// Shared types and constants for the shield SPI master.
// Holds the FSM state encoding, transfer widths and idle pin levels.
package shield_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_TRAIL
    } spi_state_e;

    localparam int SPI_DATA_W = 8;

    // 16 half-periods per byte, so a 4-bit counter wraps cleanly after the last one.
    localparam int HCNT_W = 4;
    localparam logic [HCNT_W-1:0] HCNT_LAST = 4'd15;
    localparam logic [HCNT_W-1:0] HCNT_ONE  = 4'd1;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic MOSI_RST  = 1'b0;
    localparam logic SS_N_IDLE = 1'b1;

endpackage

// File: rtl/shield_spi_clkgen.sv
// SCK half-period generator: latches the divider on load, ticks once every
// H = div+1 cycles while running, and toggles SCK on ticks when enabled.
module shield_spi_clkgen
    import shield_spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             run_i,
    input  logic             sck_en_i,
    output logic             tick_o,
    output logic             sck_o
);

    localparam logic [DIV_W:0] ONE = {{DIV_W{1'b0}}, 1'b1};

    // One extra bit so an all-ones divider gives H = 2**DIV_W without wrapping.
    logic [DIV_W:0] half_q, half_d;
    logic [DIV_W:0] cnt_q, cnt_d;
    logic           sck_q, sck_d;

    assign tick_o = run_i && (cnt_q == (half_q - ONE));
    assign sck_o  = sck_q;

    always_comb begin
        half_d = half_q;
        cnt_d  = cnt_q;
        sck_d  = sck_q;
        if (load_i) begin
            half_d = {1'b0, div_i} + ONE;
            cnt_d  = '0;
            sck_d  = SCK_IDLE;
        end else if (run_i) begin
            if (tick_o) begin
                cnt_d = '0;
                if (sck_en_i) begin
                    sck_d = ~sck_q;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            half_q <= ONE;
            cnt_q  <= '0;
            sck_q  <= SCK_IDLE;
        end else begin
            half_q <= half_d;
            cnt_q  <= cnt_d;
            sck_q  <= sck_d;
        end
    end

endmodule

// File: rtl/shield_spi_master.sv
// Byte-oriented mode-0 SPI master for the shield pins, with chip-select hold
// between bytes for multi-byte EEPROM transactions.
module shield_spi_master
    import shield_spi_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [DIV_W-1:0]  CLK_DIV,
    input  logic              CS_HOLD,
    input  logic              TX_VALID,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic              TX_READY,
    output logic              RX_VALID,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              BUSY,
    output logic              SPI_SCK,
    output logic              SPI_MOSI,
    output logic              SPI_SS_N,
    input  logic              SPI_MISO
);

    spi_state_e state_q, state_d;

    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              mosi_q, mosi_d;
    logic              ss_n_q, ss_n_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;

    logic accept;
    logic gen_load;
    logic gen_run;
    logic gen_sck_en;
    logic gen_tick;

    assign TX_READY = PRESETn && ((state_q == ST_IDLE) || (state_q == ST_GAP));
    assign accept   = TX_VALID && TX_READY;
    assign BUSY     = (state_q != ST_IDLE);
    assign RX_VALID = rx_valid_q;
    assign RX_DATA  = rx_data_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_SS_N = ss_n_q;

    shield_spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk_i    (PCLK),
        .rst_ni   (PRESETn),
        .load_i   (gen_load),
        .div_i    (CLK_DIV),
        .run_i    (gen_run),
        .sck_en_i (gen_sck_en),
        .tick_o   (gen_tick),
        .sck_o    (SPI_SCK)
    );

    // Even half-period ticks raise SCK and sample MISO; odd ones lower SCK and advance MOSI.
    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        hcnt_d     = hcnt_q;
        gen_load   = 1'b0;
        gen_run    = 1'b0;
        gen_sck_en = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (accept) begin
                    gen_load = 1'b1;
                    tx_sh_d  = TX_DATA;
                    mosi_d   = TX_DATA[DATA_W-1];
                    ss_n_d   = 1'b0;
                    hcnt_d   = '0;
                    state_d  = ST_SHIFT;
                end else if ((state_q == ST_GAP) && !CS_HOLD) begin
                    state_d = ST_TRAIL;
                end
            end
            ST_SHIFT: begin
                gen_run    = 1'b1;
                gen_sck_en = 1'b1;
                if (gen_tick) begin
                    hcnt_d = hcnt_q + HCNT_ONE;
                    if (!hcnt_q[0]) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], SPI_MISO};
                    end else if (hcnt_q == HCNT_LAST) begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        state_d    = CS_HOLD ? ST_GAP : ST_TRAIL;
                    end else begin
                        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                        mosi_d  = tx_sh_q[DATA_W-2];
                    end
                end
            end
            ST_TRAIL: begin
                gen_run = 1'b1;
                if (gen_tick) begin
                    ss_n_d  = SS_N_IDLE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= MOSI_RST;
            ss_n_q     <= SS_N_IDLE;
            hcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            hcnt_q     <= hcnt_d;
        end
    end

endmodule

// File: tb/tb_shield_spi_master.sv
// Self-checking bench for shield_spi_master: a mode-0 SPI slave model feeds MISO,
// and queued expectations for RX bytes, MOSI bytes and their timing are checked.
module tb_shield_spi_master;

    localparam int DIV_W = 8;

    logic             PCLK     = 1'b0;
    logic             PRESETn  = 1'b0;
    logic [DIV_W-1:0] CLK_DIV  = '0;
    logic             CS_HOLD  = 1'b0;
    logic             TX_VALID = 1'b0;
    logic [7:0]       TX_DATA  = '0;
    logic             TX_READY;
    logic             RX_VALID;
    logic [7:0]       RX_DATA;
    logic             BUSY;
    logic             SPI_SCK;
    logic             SPI_MOSI;
    logic             SPI_SS_N;
    logic             SPI_MISO = 1'b0;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] when;
    } rxExp_t;

    rxExp_t     rxQ[$];
    logic [7:0] txQ[$];
    logic [7:0] devResp[$];

    int testsRun    = 0;
    int testsFailed = 0;
    int cycCount    = 0;
    int ssRises     = 0;

    logic [7:0] devSh   = 8'hFF;
    int         devBits = 0;
    logic [7:0] mosiSh  = '0;
    int         mosiCnt = 0;
    logic       ssPrev  = 1'b1;
    logic       sckPrev = 1'b0;
    rxExp_t     monExp;
    logic [7:0] monTx;

    shield_spi_master #(
        .DIV_W  (DIV_W),
        .DATA_W (8)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .CLK_DIV  (CLK_DIV),
        .CS_HOLD  (CS_HOLD),
        .TX_VALID (TX_VALID),
        .TX_DATA  (TX_DATA),
        .TX_READY (TX_READY),
        .RX_VALID (RX_VALID),
        .RX_DATA  (RX_DATA),
        .BUSY     (BUSY),
        .SPI_SCK  (SPI_SCK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_SS_N (SPI_SS_N),
        .SPI_MISO (SPI_MISO)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cycCount <= cycCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycCount);
        end
    endtask

    // Offer a byte and wait for the accept edge; t0 is the cycle count of that edge.
    task automatic applyStimulus(input logic [7:0] txd, input logic [7:0] rxExp, input logic hold,
                                 input int h, input bit expectRx, output int t0);
        int  waitCyc;
        bit  done;
        logic rdy;
        TX_DATA  = txd;
        TX_VALID = 1'b1;
        CS_HOLD  = hold;
        waitCyc  = 0;
        done     = 0;
        while (!done) begin
            rdy = TX_READY;
            @(posedge PCLK);
            #1;
            if (rdy) begin
                done = 1;
            end else begin
                waitCyc++;
                if (waitCyc > 4000) begin
                    checkOutput("accept_timeout", 0, 1);
                    done = 1;
                end
            end
        end
        t0 = cycCount;
        if (expectRx) begin
            rxQ.push_back('{data: rxExp, when: t0 + 16 * h});
            txQ.push_back(txd);
        end
    endtask

    task automatic waitSsHigh(input int expCyc, input string name);
        int n;
        n = 0;
        while (!SPI_SS_N && n < 5000) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        checkOutput({name, "_ss_rise_cycle"}, cycCount, expCyc);
        checkOutput({name, "_busy_low"}, {31'd0, BUSY}, 0);
    endtask

    task automatic stepCycles(input int k);
        repeat (k) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Slave model and monitors, all sampled mid-cycle away from the active edge.
    always @(negedge PCLK) begin
        if (ssPrev && !SPI_SS_N) begin
            devSh   = (devResp.size() > 0) ? devResp.pop_front() : 8'hFF;
            devBits = 0;
            SPI_MISO = devSh[7];
        end else if (!SPI_SS_N && sckPrev && !SPI_SCK) begin
            devBits++;
            if (devBits == 8) begin
                devBits = 0;
                devSh   = (devResp.size() > 0) ? devResp.pop_front() : 8'hFF;
            end else begin
                devSh = {devSh[6:0], 1'b0};
            end
            SPI_MISO = devSh[7];
        end
        if (!ssPrev && SPI_SS_N) begin
            ssRises++;
            mosiCnt = 0;
            devBits = 0;
        end
        if (!sckPrev && SPI_SCK) begin
            mosiSh = {mosiSh[6:0], SPI_MOSI};
            mosiCnt++;
            if (mosiCnt == 8) begin
                mosiCnt = 0;
                if (txQ.size() == 0) begin
                    checkOutput("mosi_unexpected_byte", {24'd0, mosiSh}, 0);
                end else begin
                    monTx = txQ.pop_front();
                    checkOutput("mosi_byte", {24'd0, mosiSh}, {24'd0, monTx});
                end
            end
        end
        if (RX_VALID) begin
            if (rxQ.size() == 0) begin
                checkOutput("rx_unexpected", {24'd0, RX_DATA}, 32'hFFFF_FFFF);
            end else begin
                monExp = rxQ.pop_front();
                checkOutput("rx_data", {24'd0, RX_DATA}, {24'd0, monExp.data});
                checkOutput("rx_cycle", cycCount, monExp.when);
            end
        end
        ssPrev  = SPI_SS_N;
        sckPrev = SPI_SCK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   t0, t0b, n, hi, lo, rises, readyHigh, ssBase;
        logic prevSck;

        // Reset values
        stepCycles(3);
        checkOutput("rst_ss_n", {31'd0, SPI_SS_N}, 1);
        checkOutput("rst_sck", {31'd0, SPI_SCK}, 0);
        checkOutput("rst_mosi", {31'd0, SPI_MOSI}, 0);
        checkOutput("rst_rx_valid", {31'd0, RX_VALID}, 0);
        checkOutput("rst_rx_data", {24'd0, RX_DATA}, 0);
        checkOutput("rst_busy", {31'd0, BUSY}, 0);
        checkOutput("rst_tx_ready", {31'd0, TX_READY}, 0);
        PRESETn = 1'b1;
        stepCycles(1);
        checkOutput("idle_tx_ready", {31'd0, TX_READY}, 1);

        // Single byte, H=1: 0xA5 out, 0x3C back
        CLK_DIV = 8'd0;
        devResp.push_back(8'h3C);
        applyStimulus(8'hA5, 8'h3C, 1'b0, 1, 1, t0);
        TX_VALID = 1'b0;
        checkOutput("single_ss_low", {31'd0, SPI_SS_N}, 0);
        checkOutput("single_mosi_msb", {31'd0, SPI_MOSI}, 1);
        waitSsHigh(t0 + 17, "single");
        stepCycles(2);

        // H=4 timing, divider change after accept must be ignored
        CLK_DIV = 8'd3;
        devResp.push_back(8'h5A);
        applyStimulus(8'hFF, 8'h5A, 1'b0, 4, 1, t0);
        TX_VALID = 1'b0;
        CLK_DIV  = 8'd0;
        n = 0;
        while (!SPI_SCK && n < 100) begin
            stepCycles(1);
            n++;
        end
        checkOutput("div3_first_rise", cycCount, t0 + 4);
        hi = 0;
        while (SPI_SCK && hi < 100) begin
            stepCycles(1);
            hi++;
        end
        checkOutput("div3_sck_high_len", hi, 4);
        lo = 0;
        while (!SPI_SCK && lo < 100) begin
            stepCycles(1);
            lo++;
        end
        checkOutput("div3_sck_low_len", lo, 4);
        waitSsHigh(t0 + 68, "div3");
        stepCycles(2);

        // EEPROM RDSR: opcode 0x05 then dummy 0x00 with SS held, status 0x00
        CLK_DIV = 8'd1;
        ssBase  = ssRises;
        devResp.push_back(8'hFF);
        devResp.push_back(8'h00);
        applyStimulus(8'h05, 8'hFF, 1'b1, 2, 1, t0);
        applyStimulus(8'h00, 8'h00, 1'b1, 2, 1, t0b);
        TX_VALID = 1'b0;
        CS_HOLD  = 1'b0;
        checkOutput("rdsr_second_accept", t0b, t0 + 33);
        waitSsHigh(t0b + 34, "rdsr");
        stepCycles(1);
        checkOutput("rdsr_single_ss_rise", ssRises, ssBase + 1);
        stepCycles(2);

        // Back-pressure: TX_VALID stays high, second byte waits for GAP
        CLK_DIV = 8'd0;
        devResp.push_back(8'h96);
        devResp.push_back(8'h69);
        applyStimulus(8'h11, 8'h96, 1'b1, 1, 1, t0);
        TX_DATA   = 8'h22;
        readyHigh = 0;
        while (cycCount < t0 + 16) begin
            if (TX_READY) readyHigh++;
            stepCycles(1);
        end
        checkOutput("bp_ready_low_in_shift", readyHigh, 0);
        applyStimulus(8'h22, 8'h69, 1'b1, 1, 1, t0b);
        TX_VALID = 1'b0;
        CS_HOLD  = 1'b0;
        checkOutput("bp_second_accept", t0b, t0 + 17);
        waitSsHigh(t0b + 17, "bp");
        stepCycles(2);

        // Reset at the 5th SCK rise of a byte
        CLK_DIV = 8'd1;
        devResp.push_back(8'hC3);
        applyStimulus(8'h5A, 8'h00, 1'b0, 2, 0, t0);
        TX_VALID = 1'b0;
        rises    = 0;
        prevSck  = SPI_SCK;
        n        = 0;
        while (rises < 5 && n < 200) begin
            stepCycles(1);
            n++;
            if (SPI_SCK && !prevSck) rises++;
            prevSck = SPI_SCK;
        end
        checkOutput("rstmid_rises_seen", rises, 5);
        PRESETn = 1'b0;
        stepCycles(1);
        checkOutput("rstmid_ss_n", {31'd0, SPI_SS_N}, 1);
        checkOutput("rstmid_sck", {31'd0, SPI_SCK}, 0);
        checkOutput("rstmid_mosi", {31'd0, SPI_MOSI}, 0);
        checkOutput("rstmid_rx_valid", {31'd0, RX_VALID}, 0);
        checkOutput("rstmid_rx_data", {24'd0, RX_DATA}, 0);
        checkOutput("rstmid_busy", {31'd0, BUSY}, 0);
        checkOutput("rstmid_tx_ready", {31'd0, TX_READY}, 0);
        devResp.delete();
        stepCycles(1);
        PRESETn = 1'b1;
        stepCycles(1);
        CLK_DIV = 8'd0;
        devResp.push_back(8'hE7);
        applyStimulus(8'h3A, 8'hE7, 1'b0, 1, 1, t0);
        TX_VALID = 1'b0;
        waitSsHigh(t0 + 17, "post_rst");
        stepCycles(2);

        // Accept in GAP together with CS_HOLD=0: new byte runs, then TRAIL
        CLK_DIV = 8'd2;
        ssBase  = ssRises;
        devResp.push_back(8'h12);
        devResp.push_back(8'h34);
        applyStimulus(8'hC0, 8'h12, 1'b1, 3, 1, t0);
        TX_VALID = 1'b0;
        n = 0;
        while (!TX_READY && n < 1000) begin
            stepCycles(1);
            n++;
        end
        checkOutput("gap_reached", cycCount, t0 + 48);
        applyStimulus(8'h0F, 8'h34, 1'b0, 3, 1, t0b);
        TX_VALID = 1'b0;
        checkOutput("gap_accept_cycle", t0b, t0 + 49);
        checkOutput("gap_ss_still_low", {31'd0, SPI_SS_N}, 0);
        waitSsHigh(t0b + 51, "gap");
        stepCycles(1);
        checkOutput("gap_single_ss_rise", ssRises, ssBase + 1);

        stepCycles(4);
        checkOutput("rx_queue_drained", rxQ.size(), 0);
        checkOutput("mosi_queue_drained", txQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/shield_spi_master.md
Name: shield_spi_master

Overview:
- Byte-oriented SPI master (mode 0: CPOL=0, CPHA=0) that drives the shield SPI pins SH_IO[13] (SCK), SH_IO[11] (MOSI), SH_IO[10] (SS) and samples SH_IO[12] (MISO).
- Sits directly upstream of the shield's SPI mux and the SPI EEPROM model.
- Accepts bytes over a valid/ready handshake and returns each received byte as a one-cycle pulse.
- Supports multi-byte transactions with chip-select held low between bytes (EEPROM opcode + address + data).

Parameters:
- DIV_W, 8, width of the CLK_DIV input.
- DATA_W, 8, bits per transfer; only 8 supported, MSB first.

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESETn  input  1  reset; synchronous, active-low.
- CLK_DIV  input  DIV_W  SCK half-period minus 1, in PCLK cycles (H = CLK_DIV+1).
- CS_HOLD  input  1  1 = keep SS asserted after the current byte for a follow-on byte.
- TX_VALID  input  1  byte offered.
- TX_DATA  input  8  byte to transmit.
- TX_READY  output  1  byte accepted when TX_VALID & TX_READY.
- RX_VALID  output  1  one-cycle pulse; RX_DATA valid.
- RX_DATA  output  8  last received byte, held until next RX_VALID.
- BUSY  output  1  high whenever state != IDLE.
- SPI_SCK  output  1  serial clock, idle low.
- SPI_MOSI  output  1  serial data out.
- SPI_SS_N  output  1  chip select, active-low.
- SPI_MISO  input  1  serial data in.

Behaviour:
- Reset (PRESETn low at a PCLK edge, any state, including mid-byte):
  - State = IDLE.
  - SPI_SS_N=1, SPI_SCK=0, SPI_MOSI=0, RX_VALID=0, RX_DATA=0x00, BUSY=0.
  - TX_READY=0 while PRESETn is low.
  - The partial byte is discarded and no RX_VALID is issued.
- States: IDLE, SHIFT, GAP, TRAIL.
- IDLE:
  - TX_READY=1.
  - On accept at edge t0: CLK_DIV is latched (later changes ignored until the next accept from IDLE) and TX_DATA is loaded into the shift register.
  - At t0+1: SPI_SS_N=0, SPI_MOSI=TX_DATA[7], state = SHIFT.
- SHIFT:
  - The half-period counter counts H cycles per half-period; 16 half-periods per byte.
  - Rising SCK edges at t0+1+(2k+1)H, k=0..7. MISO is sampled into the receive shift register on the same PCLK edge that raises SCK.
  - Falling SCK edges at t0+1+(2k+2)H. On each falling edge except the last, MOSI advances to the next lower bit.
  - On the 8th falling edge (t0+1+16H):
    - RX_VALID=1 for exactly one cycle; RX_DATA = received byte.
    - SPI_MOSI holds its last bit.
    - Next state is GAP if CS_HOLD=1, otherwise TRAIL.
  - TX_READY=0 throughout SHIFT; TX_VALID is ignored.
- GAP:
  - SPI_SS_N=0, SPI_SCK=0, TX_READY=1.
  - On accept: load the byte and CLK_DIV, MOSI=bit7 on the next cycle, enter SHIFT with identical timing relative to the accept edge.
  - If CS_HOLD drops with no accept in the same cycle, go to TRAIL.
  - Simultaneous accept and CS_HOLD=0: the accept wins; CS_HOLD is re-evaluated at the end of the new byte.
- TRAIL:
  - SPI_SS_N stays low for H cycles, then goes 1 and state returns to IDLE.
  - TX_READY=0 during TRAIL.
- Minimum SS-high time between transactions: 1 PCLK cycle (IDLE accept cannot occur in the same cycle SS rises).
- CLK_DIV=0 is legal (H=1, SCK = PCLK/2). CLK_DIV=all-ones gives H=256. The counter is DIV_W+1 bits wide so it does not wrap.
- MISO is captured as presented. No synchronizer is used; the testbench device shares PCLK timing.

Decomposition:
- Package shield_spi_pkg:
  - State enum (IDLE, SHIFT, GAP, TRAIL).
  - DATA_W and bit-count width constant (4 bits, counting 0..15 half-periods).
  - Reset-value constants for the SPI pins.
- Sub-module shield_spi_clkgen:
  - Half-period counter with a load on start and a one-cycle tick output; it also toggles SCK.
  - The FSM and shift registers remain in the top module.

Test Plan:
- Single byte, CLK_DIV=0:
  - Stimulus: TX 0xA5; device returns 0x3C.
  - Required: MOSI sampled at SCK rises is 1,0,1,0,0,1,0,1; RX_VALID exactly at t0+17 with RX_DATA=0x3C; SS_N rises at t0+18; BUSY low from t0+18.
- Timing, CLK_DIV=3:
  - Stimulus: TX 0xFF.
  - Required: SCK high for 4 cycles and low for 4 cycles; first rise at t0+5; RX_VALID at t0+65.
- EEPROM RDSR with CS_HOLD=1:
  - Stimulus: TX 0x05, then 0x00, then drop CS_HOLD.
  - Required: SS_N stays low across both bytes; second RX_DATA = status register value (0x00 after reset); SS_N high H cycles after the second RX_VALID.
- Busy back-pressure:
  - Stimulus: TX_VALID held high with 0x11 then 0x22 during byte 1.
  - Required: TX_READY=0 throughout SHIFT; 0x22 is not consumed until GAP or IDLE; no byte is lost or duplicated.
- Reset mid-byte:
  - Stimulus: PRESETn low at the 5th SCK rise.
  - Required: at the next edge SS_N=1, SCK=0, MOSI=0, no RX_VALID; the next transaction after reset completes normally.
- Simultaneous accept and CS_HOLD=0 in GAP:
  - Required: the new byte transfers with SS_N continuously low; the transaction then ends via TRAIL.
